multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle RV32I core.
//  - Sequences the shared ALU, memory, IR/PC registers and extender per instruction.
//  - Decodes ALUControl and ImmSrc.
//  - Stalls on a memory ready handshake and aborts stuck accesses after a timeout.
// PARAMETERS
//  WAIT_LIMIT  16  max consecutive !i_memReady cycles in a memory state; 0 = no timeout
//  WAIT_W      $clog2(WAIT_LIMIT+1)  wait-counter width (derived, do not override)
// PORTS
//  i_clk           in   1  clock
//  i_rst_n         in   1  asynchronous active-low reset
//  i_opcode        in   7  instr[6:0] from IR
//  i_funct3        in   3  instr[14:12]
//  i_funct7b5      in   1  instr[30]
//  i_zero          in   1  ALU zero flag
//  i_memReady      in   1  memory completes access this cycle
//  o_pcWrite       out  1  PC load enable
//  o_adrSrc        out  1  0=PC, 1=ALUOut to memory address
//  o_memWrite      out  1  memory write strobe
//  o_irWrite       out  1  IR/OldPC load enable
//  o_regWrite      out  1  register file write enable
//  o_resultSrc     out  2  00 ALUOut, 01 Data, 10 ALUResult
//  o_aluSrcA       out  2  00 PC, 01 OldPC, 10 RD1
//  o_aluSrcB       out  2  00 RD2, 01 ImmExt, 10 constant 4
//  o_immSrc        out  2  00 I, 01 S, 10 B
//  o_aluControl    out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  o_illegal       out  1  one-cycle pulse: unsupported opcode seen in DECODE
//  o_memTimeout    out  1  one-cycle pulse: memory wait aborted
// BEHAVIOUR
//  - Reset: state=FETCH, wait counter=0, flags=0.
//    Outputs are Moore functions of state, gated by i_memReady where noted.
//  - Opcodes: LW 0000011, SW 0100011, R 0110011, BEQ 1100011.
//  - State outputs (all unlisted outputs 0):
//    FETCH     adrSrc=0, aluSrcA=00, aluSrcB=10, add, resultSrc=10;
//              irWrite=pcWrite=i_memReady; advance to DECODE on i_memReady, else hold.
//    DECODE    aluSrcA=01, aluSrcB=01, add (branch target into ALUOut);
//              next by opcode: LW/SW->MEMADR, R->EXECR, BEQ->BEQ,
//              other->FETCH with o_illegal=1.
//    MEMADR    aluSrcA=10, aluSrcB=01, add; LW->MEMREAD, SW->MEMWRITE.
//    MEMREAD   adrSrc=1; hold until i_memReady, then MEMWB.
//    MEMWB     resultSrc=01, regWrite=1; ->FETCH.
//    MEMWRITE  adrSrc=1, memWrite=1; hold until i_memReady, then FETCH.
//    EXECR     aluSrcA=10, aluSrcB=00, funct decode; ->ALUWB.
//    ALUWB     resultSrc=00, regWrite=1; ->FETCH.
//    BEQ       aluSrcA=10, aluSrcB=00, sub, resultSrc=00, pcWrite=i_zero; ->FETCH.
//  - immSrc by opcode in every state: LW/I-type=00, SW=01, BEQ=10, else 00.
//  - Funct decode (R):
//    f3=000: f7b5 ? sub : add; 010 slt; 110 or; 111 and; other -> add.
//  - Cycles with i_memReady=1: BEQ 3, R/SW 4, LW 5.
//    Each memory state adds one cycle per !i_memReady cycle.
//  - Wait counter:
//    - Increments per !i_memReady cycle in FETCH/MEMREAD/MEMWRITE.
//    - Clears on any state change or on i_memReady.
//    - Reaching WAIT_LIMIT: o_memTimeout=1 for one cycle, next state=FETCH,
//      counter=0, no strobes.
//    - i_memReady and the limit in the same cycle: i_memReady wins, no timeout.
//    - Counter saturates; no wrap.
//  - Reset asserted mid-instruction: immediate return to FETCH.
//    Partially issued access is discarded.
// CONFIGURATION
//  RISCV_ITYPE_ALU_EN
//    Defined: opcode 0010011 decodes DECODE->EXECI->ALUWB.
//      EXECI: aluSrcA=10, aluSrcB=01, funct decode with f7b5 ignored (addi never subtracts).
//      4 cycles.
//    Undefined: 0010011 is illegal, giving o_illegal and a return to FETCH.
// TESTING
//  - Reset, memReady=1, R add (f3=000, f7b5=0): FETCH->DECODE->EXECR->ALUWB;
//    aluControl=000 in EXECR, regWrite=1 only in ALUWB, back in FETCH at cycle 4.
//  - LW with memReady low for 3 cycles in MEMREAD: stays 3 extra cycles;
//    resultSrc=01, regWrite=1 in MEMWB; total 8 cycles.
//  - BEQ with i_zero=1 -> pcWrite=1 in BEQ;
//    repeat with i_zero=0 -> pcWrite=0; aluControl=001, immSrc=10.
//  - SW with memReady held low, WAIT_LIMIT=16:
//    o_memTimeout pulses after 16 wait cycles, next state FETCH, memWrite drops.
//  - Opcode 1111111 -> o_illegal pulse in DECODE, FETCH next, no regWrite/memWrite.
//  - With RISCV_ITYPE_ALU_EN, addi f7b5=1 -> aluSrcB=01, aluControl=000, 4 cycles;
//    without the macro -> o_illegal.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences datapath per instruction, stalls on memory ready.
// Optional I-type ALU support (addi/slti/ori/andi) is enabled by defining RISCV_ITYPE_ALU_EN.
module multicycle_controller #(
  parameter int WAIT_LIMIT = 16,
  parameter int WAIT_W     = $clog2(WAIT_LIMIT + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_memReady,
  output logic       o_pcWrite,
  output logic       o_adrSrc,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_regWrite,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_immSrc,
  output logic [2:0] o_aluControl,
  output logic       o_illegal,
  output logic       o_memTimeout
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  // A zero-width counter is impossible, so WAIT_LIMIT=0 still keeps one bit.
  localparam int               CNT_W   = (WAIT_W < 1) ? 1 : WAIT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(WAIT_LIMIT);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             waiting;
  logic             timeout;

  function automatic logic [2:0] aluDecode(input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'b000:  aluDecode = f7b5 ? 3'b001 : 3'b000;
      3'b010:  aluDecode = 3'b101;
      3'b110:  aluDecode = 3'b011;
      3'b111:  aluDecode = 3'b010;
      default: aluDecode = 3'b000;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  always_comb begin
    case (i_opcode)
      OP_SW:   o_immSrc = 2'b01;
      OP_BEQ:  o_immSrc = 2'b10;
      default: o_immSrc = 2'b00;
    endcase
  end

  // A ready in the limit cycle still completes normally; only a stuck access aborts.
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                   && !i_memReady;
  assign timeout = waiting && (WAIT_LIMIT != 0) && (waitCnt_q == LIMIT);

  always_comb begin
    state_d      = state_q;
    waitCnt_d    = '0;
    o_pcWrite    = 1'b0;
    o_adrSrc     = 1'b0;
    o_memWrite   = 1'b0;
    o_irWrite    = 1'b0;
    o_regWrite   = 1'b0;
    o_resultSrc  = 2'b00;
    o_aluSrcA    = 2'b00;
    o_aluSrcB    = 2'b00;
    o_aluControl = 3'b000;
    o_illegal    = 1'b0;
    o_memTimeout = timeout;

    if (waiting && !timeout) begin
      waitCnt_d = (waitCnt_q == CNT_MAX) ? waitCnt_q : waitCnt_q + 1'b1;
    end

    case (state_q)
      S_FETCH: begin
        o_aluSrcB   = 2'b10;
        o_resultSrc = 2'b10;
        if (i_memReady) begin
          o_irWrite = 1'b1;
          o_pcWrite = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b01;
        case (i_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_BEQ:       state_d = S_BEQ;
`ifdef RISCV_ITYPE_ALU_EN
          OP_ITYPE:     state_d = S_EXECI;
`endif
          default: begin
            o_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_aluSrcA = 2'b10;
        o_aluSrcB = 2'b01;
        if (i_opcode == OP_LW)      state_d = S_MEMREAD;
        else if (i_opcode == OP_SW) state_d = S_MEMWRITE;
        else                        state_d = S_FETCH;
      end
      S_MEMREAD: begin
        o_adrSrc = 1'b1;
        if (timeout)         state_d = S_FETCH;
        else if (i_memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultSrc = 2'b01;
        o_regWrite  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adrSrc = 1'b1;
        if (timeout) begin
          state_d = S_FETCH;
        end else begin
          o_memWrite = 1'b1;
          if (i_memReady) state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        o_aluSrcA    = 2'b10;
        o_aluControl = aluDecode(i_funct3, i_funct7b5);
        state_d      = S_ALUWB;
      end
      S_EXECI: begin
        o_aluSrcA    = 2'b10;
        o_aluSrcB    = 2'b01;
        o_aluControl = aluDecode(i_funct3, 1'b0);
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        o_regWrite = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        o_aluSrcA    = 2'b10;
        o_aluControl = 3'b001;
        o_pcWrite    = i_zero;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle
// and compares the packed control outputs against hand-computed vectors.
module tb_multicycle_controller;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic       i_memReady;
  logic       o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite;
  logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc;
  logic [2:0] o_aluControl;
  logic       o_illegal, o_memTimeout;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  multicycle_controller #(.WAIT_LIMIT(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_memReady(i_memReady),
    .o_pcWrite(o_pcWrite), .o_adrSrc(o_adrSrc), .o_memWrite(o_memWrite),
    .o_irWrite(o_irWrite), .o_regWrite(o_regWrite), .o_resultSrc(o_resultSrc),
    .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_immSrc(o_immSrc),
    .o_aluControl(o_aluControl), .o_illegal(o_illegal), .o_memTimeout(o_memTimeout)
  );

  always #5 i_clk = ~i_clk;

  // Packed order: pcW adr memW irW regW res[2] srcA[2] srcB[2] imm[2] alu[3] ill tmo
  logic [17:0] obsVec;
  assign obsVec = {o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite, o_resultSrc,
                   o_aluSrcA, o_aluSrcB, o_immSrc, o_aluControl, o_illegal, o_memTimeout};

  task automatic checkOutput(input string tag, input logic [17:0] observed,
                             input logic [17:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic zero, input logic ready);
    i_opcode   = op;
    i_funct3   = f3;
    i_funct7b5 = f7;
    i_zero     = zero;
    i_memReady = ready;
  endtask

  // Called just after a falling edge with inputs applied; checks, then moves to next cycle.
  task automatic runCycle(input string tag, input logic [17:0] expected);
    #1;
    checkOutput(tag, obsVec, expected);
    @(negedge i_clk);
  endtask

  function automatic logic [17:0] pack(input logic pcW, input logic adr, input logic memW,
      input logic irW, input logic regW, input logic [1:0] res, input logic [1:0] srcA,
      input logic [1:0] srcB, input logic [1:0] imm, input logic [2:0] alu,
      input logic ill, input logic tmo);
    pack = {pcW, adr, memW, irW, regW, res, srcA, srcB, imm, alu, ill, tmo};
  endfunction

  initial begin
    i_rst_n = 1'b0;
    applyStimulus(OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_fetch", obsVec, pack(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // R add
    applyStimulus(OP_R, 3'b000, 1'b0, 1'b0, 1'b1);
    runCycle("radd_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    runCycle("radd_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    runCycle("radd_execr",  pack(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0,0));
    runCycle("radd_aluwb",  pack(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));

    // R sub / slt / and / or: only EXECR differs
    applyStimulus(OP_R, 3'b000, 1'b1, 1'b0, 1'b1);
    runCycle("rsub_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    runCycle("rsub_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    runCycle("rsub_execr",  pack(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0));
    runCycle("rsub_aluwb",  pack(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    applyStimulus(OP_R, 3'b010, 1'b0, 1'b0, 1'b1);
    runCycle("rslt_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    runCycle("rslt_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    runCycle("rslt_execr",  pack(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101,0,0));
    runCycle("rslt_aluwb",  pack(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    applyStimulus(OP_R, 3'b111, 1'b0, 1'b0, 1'b1);
    runCycle("rand_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    runCycle("rand_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    runCycle("rand_execr",  pack(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0,0));
    runCycle("rand_aluwb",  pack(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    applyStimulus(OP_R, 3'b110, 1'b0, 1'b0, 1'b1);
    runCycle("ror_fetch",   pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    runCycle("ror_decode",  pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    runCycle("ror_execr",   pack(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011,0,0));
    runCycle("ror_aluwb",   pack(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));

    // LW with three stall cycles in MEMREAD: 8 cycles total
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
    runCycle("lw_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    runCycle("lw_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    runCycle("lw_memadr", pack(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    i_memReady = 1'b0;
    for (int i = 0; i < 3; i++)
      runCycle("lw_memread_wait", pack(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    i_memReady = 1'b1;
    runCycle("lw_memread_done", pack(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    runCycle("lw_memwb",  pack(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0,0));
    runCycle("lw_back_fetch", pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));

    // That fetch started a new LW; stall 16 cycles then ready at the limit wins
    runCycle("lw2_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    runCycle("lw2_memadr", pack(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    i_memReady = 1'b0;
    for (int i = 0; i < 16; i++)
      runCycle("lw2_wait", pack(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    i_memReady = 1'b1;
    runCycle("lw2_ready_at_limit", pack(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    runCycle("lw2_memwb", pack(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0,0));

    // BEQ taken then not taken
    applyStimulus(OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1);
    runCycle("beq1_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
    runCycle("beq1_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
    runCycle("beq1_taken",  pack(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));
    i_zero = 1'b0;
    runCycle("beq0_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
    runCycle("beq0_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
    runCycle("beq0_not",    pack(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));

    // SW normal, then SW stuck until timeout
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
    runCycle("sw_fetch",    pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
    runCycle("sw_decode",   pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
    runCycle("sw_memadr",   pack(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
    runCycle("sw_memwrite", pack(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
    runCycle("sw2_fetch",   pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
    runCycle("sw2_decode",  pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
    runCycle("sw2_memadr",  pack(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
    i_memReady = 1'b0;
    for (int i = 0; i < 16; i++)
      runCycle("sw2_wait", pack(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
    runCycle("sw2_timeout", pack(0,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,1));
    runCycle("sw2_after_fetch", pack(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));

    // Illegal opcode
    applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1);
    runCycle("bad_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    runCycle("bad_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1,0));
    runCycle("bad_fetch2", pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));

    // addi with f7b5=1 (the fetch above already loaded it)
    applyStimulus(OP_ITYPE, 3'b000, 1'b1, 1'b0, 1'b1);
`ifdef RISCV_ITYPE_ALU_EN
    runCycle("addi_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    runCycle("addi_execi",  pack(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    runCycle("addi_aluwb",  pack(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    runCycle("addi_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
`else
    runCycle("addi_decode_illegal", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1,0));
    runCycle("addi_fetch",  pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
`endif

    // Async reset in the middle of an LW returns straight to FETCH
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
    runCycle("lw3_decode", pack(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    runCycle("lw3_memadr", pack(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    i_memReady = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset_fetch", obsVec, pack(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    @(negedge i_clk);
    i_rst_n    = 1'b1;
    i_memReady = 1'b1;
    runCycle("postreset_fetch", pack(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
